// File: rtl/muldiv_hilo_unit_if.sv
// Start/Busy/Done bundle between the issue logic and the HI/LO unit.
// master drives Start/Op/A/B; slave returns Busy/Done/DivZero/HI/LO.
interface muldiv_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, Op, A, B,
    input  Busy, Done, DivZero, HI, LO
  );

  modport slave (
    input  Start, Op, A, B,
    output Busy, Done, DivZero, HI, LO
  );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative mul/div unit owning HI/LO; one product/quotient bit per cycle.
// Ports: Clk, Rst (async active-low), bus (slave: Start/Op/A/B in, Busy/Done/DivZero/HI/LO out).
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input logic Clk,
  input logic Rst,
  muldiv_hilo_unit_if.slave bus
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINAL
  } state_e;

  state_e st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] wlo_q, wlo_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;
  logic [2:0] op_q, op_d;
  logic negp_q, negp_d;
  logic nega_q, nega_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic dz_q, dz_d;

  logic sgn_in;
  logic div_in;
  logic div_q;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;
  logic [W:0] msum;
  logic [W:0] dtrial;
  logic [2*W-1:0] pmag;
  logic [2*W-1:0] pval;
  logic [2*W-1:0] hilo;
  logic [W-1:0] qv;
  logic [W-1:0] rv;

  assign sgn_in = (bus.Op == OP_MULT) || (bus.Op == OP_DIV) ||
                  (bus.Op == OP_MADD) || (bus.Op == OP_MSUB);
  assign div_in = (bus.Op == OP_DIV) || (bus.Op == OP_DIVU);
  assign div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU);

  assign a_mag = (sgn_in && bus.A[W-1]) ? -bus.A : bus.A;
  assign b_mag = (sgn_in && bus.B[W-1]) ? -bus.B : bus.B;

  // Multiply: add multiplicand when LSB of shifting multiplier is set.
  assign msum = {1'b0, acc_q} + (wlo_q[0] ? {1'b0, b_q} : '0);
  // Divide: top bit of trial is the borrow (restore when set).
  assign dtrial = {acc_q, wlo_q[W-1]} - {1'b0, b_q};

  assign pmag = {acc_q, wlo_q};
  assign pval = negp_q ? -pmag : pmag;
  assign hilo = {hi_q, lo_q};
  assign qv   = negp_q ? -wlo_q : wlo_q;
  assign rv   = nega_q ? -acc_q : acc_q;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    wlo_d  = wlo_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    op_d   = op_q;
    negp_d = negp_q;
    nega_d = nega_q;
    busy_d = busy_q;
    done_d = 1'b0;
    dz_d   = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (bus.Start) begin
          unique case (1'b1)
            (bus.Op == OP_MTHI): begin
              hi_d   = bus.A;
              done_d = 1'b1;
            end
            (bus.Op == OP_MTLO): begin
              lo_d   = bus.A;
              done_d = 1'b1;
            end
            (div_in && (bus.B == '0)): begin
              done_d = 1'b1;
              dz_d   = 1'b1;
            end
            default: begin
              st_d   = S_RUN;
              busy_d = 1'b1;
              cnt_d  = CW'(W);
              op_d   = bus.Op;
              acc_d  = '0;
              wlo_d  = a_mag;
              b_d    = b_mag;
              negp_d = sgn_in & (bus.A[W-1] ^ bus.B[W-1]);
              nega_d = sgn_in & bus.A[W-1];
            end
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (div_q) begin
          acc_d = dtrial[W] ? {acc_q[W-2:0], wlo_q[W-1]}
                            : dtrial[W-1:0];
          wlo_d = {wlo_q[W-2:0], ~dtrial[W]};
        end else begin
          acc_d = msum[W:1];
          wlo_d = {msum[0], wlo_q[W-1:1]};
        end
        if (cnt_q == CW'(1)) st_d = S_FINAL;
      end
      S_FINAL: begin
        st_d   = S_IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
        unique case (1'b1)
          div_q: begin
            lo_d = qv;
            hi_d = rv;
          end
          (op_q == OP_MADD): {hi_d, lo_d} = hilo + pval;
          (op_q == OP_MSUB): {hi_d, lo_d} = hilo - pval;
          default:           {hi_d, lo_d} = pval;
        endcase
      end
      default: begin
        st_d   = S_IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      acc_q  <= '0;
      wlo_q  <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      op_q   <= '0;
      negp_q <= 1'b0;
      nega_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      wlo_q  <= wlo_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      op_q   <= op_d;
      negp_q <= negp_d;
      nega_q <= nega_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dz_q   <= dz_d;
    end
  end

  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.DivZero = dz_q;
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit (WIDTH=32).
// Drives on negedge, samples 1ns after posedge.
module tb_muldiv_hilo_unit;
  localparam int W = 32;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MADD  = 3'b100;
  localparam logic [2:0] MSUB  = 3'b101;
  localparam logic [2:0] MTHI  = 3'b110;
  localparam logic [2:0] MTLO  = 3'b111;

  logic Clk;
  logic Rst;
  int checks;
  int failures;

  muldiv_hilo_unit_if #(.WIDTH(W)) bus ();

  muldiv_hilo_unit #(.WIDTH(W)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // k_done: index of edge E_k after which Done is first seen (E0 = 0).
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int k_done,
                        output int busy_n, output logic dz);
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op = op;
    bus.A = a;
    bus.B = b;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    k_done = -1;
    busy_n = 0;
    dz = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) begin
        @(posedge Clk);
        #1;
      end
      if (bus.Busy) busy_n++;
      if (bus.Done) begin
        k_done = k;
        dz = bus.DivZero;
        break;
      end
    end
  endtask

  int kd;
  int bn;
  logic dz;
  int dcnt;
  int k1;
  int k2;
  logic [W-1:0] lo1;
  logic [W-1:0] lo2;

  initial begin
    checks = 0;
    failures = 0;
    bus.Start = 1'b0;
    bus.Op = 3'b000;
    bus.A = '0;
    bus.B = '0;
    Rst = 1'b1;
    #2 Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_hi", bus.HI, 0);
    chk("rst_lo", bus.LO, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_dz", bus.DivZero, 0);
    @(negedge Clk);
    Rst = 1'b1;

    run_op(MULT, 32'hFFFFFFFD, 32'h7, kd, bn, dz);
    chk("mult_lat", kd, 33);
    chk("mult_busy", bn, 33);
    chk("mult_hi", bus.HI, 64'hFFFFFFFF);
    chk("mult_lo", bus.LO, 64'hFFFFFFEB);
    @(posedge Clk);
    #1;
    chk("mult_done_pulse", bus.Done, 0);

    run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, kd, bn, dz);
    chk("multu_hi", bus.HI, 64'hFFFFFFFE);
    chk("multu_lo", bus.LO, 64'h1);

    run_op(DIV, 32'hFFFFFFF9, 32'h2, kd, bn, dz);
    chk("div_lat", kd, 33);
    chk("div_lo", bus.LO, 64'hFFFFFFFD);
    chk("div_hi", bus.HI, 64'hFFFFFFFF);

    run_op(DIVU, 32'd100, 32'd7, kd, bn, dz);
    chk("divu_lo", bus.LO, 64'd14);
    chk("divu_hi", bus.HI, 64'd2);

    run_op(MTHI, 32'h0, 32'h0, kd, bn, dz);
    chk("mthi_lat", kd, 0);
    chk("mthi_busy", bn, 0);
    chk("mthi_hi", bus.HI, 0);
    run_op(MTLO, 32'hA, 32'h0, kd, bn, dz);
    chk("mtlo_lat", kd, 0);
    chk("mtlo_busy", bn, 0);
    chk("mtlo_lo", bus.LO, 64'hA);

    run_op(MADD, 32'hFFFFFFFF, 32'h5, kd, bn, dz);
    chk("madd_lat", kd, 33);
    chk("madd_hi", bus.HI, 0);
    chk("madd_lo", bus.LO, 64'h5);
    run_op(MSUB, 32'h2, 32'h3, kd, bn, dz);
    chk("msub_hi", bus.HI, 64'hFFFFFFFF);
    chk("msub_lo", bus.LO, 64'hFFFFFFFF);

    run_op(MTHI, 32'h1234, 32'h0, kd, bn, dz);
    run_op(MTLO, 32'h5678, 32'h0, kd, bn, dz);
    run_op(DIVU, 32'd100, 32'd0, kd, bn, dz);
    chk("dz_lat", kd, 0);
    chk("dz_flag", dz, 1);
    chk("dz_busy", bn, 0);
    chk("dz_hi", bus.HI, 64'h1234);
    chk("dz_lo", bus.LO, 64'h5678);
    @(posedge Clk);
    #1;
    chk("dz_pulse", bus.DivZero, 0);

    run_op(DIV, 32'h80000000, 32'hFFFFFFFF, kd, bn, dz);
    chk("ovf_lat", kd, 33);
    chk("ovf_lo", bus.LO, 64'h80000000);
    chk("ovf_hi", bus.HI, 0);
    chk("ovf_dz", dz, 0);

    // Start every cycle while a MULT is in flight (including FINAL edge).
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op = MULT;
    bus.A = 32'd3;
    bus.B = 32'd5;
    @(posedge Clk);
    #1;
    dcnt = 0;
    k1 = -1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge Clk);
      bus.Start = 1'b1;
      bus.Op = 3'(k % 8);
      bus.A = $urandom;
      bus.B = $urandom;
      @(posedge Clk);
      #1;
      if (bus.Done) begin
        dcnt++;
        k1 = k;
      end
    end
    @(negedge Clk);
    bus.Start = 1'b0;
    for (int k = 34; k <= 40; k++) begin
      @(posedge Clk);
      #1;
      if (bus.Done) dcnt++;
    end
    chk("spam_done_cnt", dcnt, 1);
    chk("spam_done_k", k1, 33);
    chk("spam_hi", bus.HI, 0);
    chk("spam_lo", bus.LO, 64'd15);
    chk("spam_busy", bus.Busy, 0);

    // Start held high: restart lands on the edge after Done.
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op = MULTU;
    bus.A = 32'd2;
    bus.B = 32'd3;
    @(posedge Clk);
    #1;
    bus.A = 32'd4;
    bus.B = 32'd5;
    k1 = -1;
    k2 = -1;
    lo1 = '0;
    lo2 = '0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge Clk);
      #1;
      if (k == 33) chk("held_busy33", bus.Busy, 0);
      if (k == 34) begin
        chk("held_busy34", bus.Busy, 1);
        bus.Start = 1'b0;
      end
      if (bus.Done) begin
        if (k1 < 0) begin
          k1 = k;
          lo1 = bus.LO;
        end else begin
          k2 = k;
          lo2 = bus.LO;
        end
      end
    end
    chk("held_k1", k1, 33);
    chk("held_lo1", lo1, 64'd6);
    chk("held_k2", k2, 67);
    chk("held_lo2", lo2, 64'd20);

    // Async reset in the middle of a DIVU.
    run_op(MTHI, 32'hDEAD, 32'h0, kd, bn, dz);
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op = DIVU;
    bus.A = 32'd1000;
    bus.B = 32'd3;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    repeat (10) @(posedge Clk);
    #2;
    chk("pre_rst_busy", bus.Busy, 1);
    Rst = 1'b0;
    #1;
    chk("arst_hi", bus.HI, 0);
    chk("arst_lo", bus.LO, 0);
    chk("arst_busy", bus.Busy, 0);
    @(negedge Clk);
    Rst = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk);
      #1;
      if (bus.Done) dcnt++;
    end
    chk("arst_no_done", dcnt, 0);
    run_op(MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, kd, bn, dz);
    chk("post_lat", kd, 33);
    chk("post_busy", bn, 33);
    chk("post_hi", bus.HI, 0);
    chk("post_lo", bus.LO, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
